// File: rtl/mem_data_sram_if_if.sv
// SRAM-like data bus between the MEM-stage master and the data memory.
// The request fields come from the master; the handshakes and read data come from the memory.
interface mem_data_sram_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        output data_wstrb,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        input  data_wstrb,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_data_sram_if.sv
// MEM-stage data master: issues one SRAM-bus access per memory instruction,
// stalls MEM until it completes and drains requests orphaned by a flush.
module mem_data_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_data_en,
    input  logic [3:0]          mem_data_ren,
    input  logic [3:0]          mem_data_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_flush,
    input  logic                wb_allowin,
    output logic                mem_stall,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_rdata_valid,
    mem_data_sram_if_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state;
    logic              drop;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;

    logic              access;
    logic              is_wr;
    logic [3:0]        mask;
    logic [2:0]        lanes;
    logic [1:0]        size_n;
    logic [ADDR_W-1:0] addr_n;

    // A store mask takes priority when both masks are set.
    always_comb begin
        access = mem_data_en & (|(mem_data_ren | mem_data_wen)) & ~mem_flush;
        is_wr  = |mem_data_wen;
        mask   = is_wr ? mem_data_wen : mem_data_ren;
        lanes  = {2'b00, mask[0]} + {2'b00, mask[1]}
               + {2'b00, mask[2]} + {2'b00, mask[3]};
        if (lanes <= 3'd1)
            size_n = 2'd0;
        else if (lanes == 3'd2)
            size_n = 2'd1;
        else
            size_n = 2'd2;
        if (size_n == 2'd2)
            addr_n = {mem_addr[ADDR_W-1:2], 2'b00};
        else
            addr_n = mem_addr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            drop    <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'd0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        state   <= S_ADDR;
                        wr_q    <= is_wr;
                        size_q  <= size_n;
                        addr_q  <= addr_n;
                        wdata_q <= mem_wdata;
                        wstrb_q <= is_wr ? mem_data_wen : 4'd0;
                    end
                end
                S_ADDR: begin
                    // The request is never retracted; a flush only marks it for draining.
                    if (mem_flush)
                        drop <= 1'b1;
                    if (bus.data_addr_ok)
                        state <= (drop | mem_flush) ? S_DRAIN : S_DATA;
                end
                S_DATA: begin
                    if (bus.data_data_ok) begin
                        rdata_q <= bus.data_rdata;
                        drop    <= 1'b0;
                        state   <= (drop | mem_flush) ? S_IDLE : S_DONE;
                    end else if (mem_flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (wb_allowin | mem_flush)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.data_data_ok) begin
                        state <= S_IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_req    = (state == S_ADDR);
    assign bus.data_wr     = wr_q;
    assign bus.data_size   = size_q;
    assign bus.data_addr   = addr_q;
    assign bus.data_wdata  = wdata_q;
    assign bus.data_wstrb  = wstrb_q;

    assign mem_rdata       = rdata_q;
    assign mem_rdata_valid = (state == S_DONE);
    assign mem_stall       = ((state == S_IDLE) & access)
                           | (state == S_ADDR)
                           | (state == S_DATA)
                           | (state == S_DRAIN);
endmodule

// File: tb/tb_mem_data_sram_if.sv
// Bench for mem_data_sram_if: directed vector table, multi-cycle corner
// sequences and a random pipeline/memory run scored by a transaction model.
module tb_mem_data_sram_if;
    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [31:0] maddr;
    logic [31:0] wdat;
    logic        flush;
    logic        wb;
    logic        stall;
    logic [31:0] rdat;
    logic        valid;

    int total;
    int bad;

    mem_data_sram_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_data_sram_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_data_en     (en),
        .mem_data_ren    (ren),
        .mem_data_wen    (wen),
        .mem_addr        (maddr),
        .mem_wdata       (wdat),
        .mem_flush       (flush),
        .wb_allowin      (wb),
        .mem_stall       (stall),
        .mem_rdata       (rdat),
        .mem_rdata_valid (valid),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        fl;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aok;
        int          dok;
        logic [31:0] rdata;
        logic        acc;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] baddr;
        logic [3:0]  strb;
    } vec_t;

    typedef struct {
        logic        en;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ins_t;

    typedef struct {
        logic        acc;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
    } exp_t;

    vec_t tv[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic en_i, input logic fl_i,
        input logic [3:0] r, input logic [3:0] w,
        input logic [31:0] a, input logic [31:0] d,
        input int ak, input int dk, input logic [31:0] rd,
        input logic ac, input logic wr_i, input logic [1:0] sz,
        input logic [31:0] ba, input logic [3:0] sb);
        vec_t v;
        v.en = en_i; v.fl = fl_i; v.ren = r; v.wen = w;
        v.addr = a; v.wdata = d; v.aok = ak; v.dok = dk;
        v.rdata = rd; v.acc = ac; v.wr = wr_i; v.size = sz;
        v.baddr = ba; v.strb = sb;
        return v;
    endfunction

    // Bus request implied by one instruction, derived from lane counting.
    function automatic exp_t ref_bus(input ins_t s, input logic fl);
        exp_t e;
        logic [3:0] m;
        int n;
        e.acc = s.en && (s.ren != 0 || s.wen != 0) && !fl;
        e.wr  = (s.wen != 0);
        m     = e.wr ? s.wen : s.ren;
        n     = 0;
        for (int i = 0; i < 4; i++)
            n += int'(m[i]);
        if (n <= 1)      e.size = 2'd0;
        else if (n == 2) e.size = 2'd1;
        else             e.size = 2'd2;
        e.addr = (e.size == 2'd2) ? (s.addr & 32'hFFFF_FFFC) : s.addr;
        e.strb = e.wr ? s.wen : 4'h0;
        return e;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t s;
        s.en = ($urandom % 6) != 0;
        case ($urandom % 4)
            0: begin s.ren = 4'hF; s.wen = 4'h0; end
            1: begin s.ren = 4'($urandom); s.wen = 4'h0; end
            2: begin s.ren = 4'h0; s.wen = 4'($urandom); end
            default: begin
                s.ren = 4'($urandom);
                s.wen = 4'($urandom);
            end
        endcase
        s.addr  = $urandom;
        s.wdata = $urandom;
        return s;
    endfunction

    task automatic idle_in();
        en = 0; ren = 0; wen = 0; maddr = 0; wdat = 0;
        flush = 0; wb = 1;
        bus.data_addr_ok = 0; bus.data_data_ok = 0;
    endtask

    task automatic present(input logic [3:0] r, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d);
        en = 1; ren = r; wen = w; maddr = a; wdat = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_rdata"}, rdat, 0);
        chk({tag, "_req"}, 32'(bus.data_req), 0);
        chk({tag, "_wr"}, 32'(bus.data_wr), 0);
        chk({tag, "_size"}, 32'(bus.data_size), 0);
        chk({tag, "_addr"}, bus.data_addr, 0);
        chk({tag, "_wdata"}, bus.data_wdata, 0);
        chk({tag, "_wstrb"}, 32'(bus.data_wstrb), 0);
    endtask

    ins_t        cur;
    ins_t        prv;
    logic        prv_fl;
    logic        hold;
    logic        outst;
    logic [31:0] last;
    logic        h_wr;
    logic [1:0]  h_size;
    logic [31:0] h_addr;
    logic [3:0]  h_strb;
    int          quiet;

    initial begin
        total = 0;
        bad   = 0;
        resetn = 0;
        bus.data_rdata = 0;
        idle_in();

        tv[0]  = mk(1, 0, 4'hF, 4'h0, 32'h8000_0010, 32'h0, 0, 0,
                    32'hDEAD_BEEF, 1, 0, 2, 32'h8000_0010, 4'h0);
        tv[1]  = mk(1, 0, 4'h0, 4'h8, 32'h8000_0003, 32'hAB00_0000, 3, 0,
                    32'h0, 1, 1, 0, 32'h8000_0003, 4'h8);
        tv[2]  = mk(1, 0, 4'hC, 4'h0, 32'h8000_0002, 32'h0, 0, 1,
                    32'h1234_5678, 1, 0, 1, 32'h8000_0002, 4'h0);
        tv[3]  = mk(1, 0, 4'h0, 4'hF, 32'h8000_0104, 32'hCAFE_F00D, 1, 0,
                    32'h0, 1, 1, 2, 32'h8000_0104, 4'hF);
        tv[4]  = mk(1, 0, 4'h0, 4'hF, 32'h8000_0107, 32'h0BAD_F00D, 0, 2,
                    32'h0, 1, 1, 2, 32'h8000_0104, 4'hF);
        tv[5]  = mk(1, 0, 4'h0, 4'h7, 32'h1000_0001, 32'h0077_6655, 2, 1,
                    32'h0, 1, 1, 2, 32'h1000_0000, 4'h7);
        tv[6]  = mk(1, 0, 4'hF, 4'h3, 32'h2000_0000, 32'h0000_BEEF, 0, 0,
                    32'h0, 1, 1, 1, 32'h2000_0000, 4'h3);
        tv[7]  = mk(0, 0, 4'hF, 4'h0, 32'h3000_0000, 32'h0, 0, 0,
                    32'h0, 0, 0, 0, 32'h0, 4'h0);
        tv[8]  = mk(1, 0, 4'h0, 4'h0, 32'h3000_0004, 32'h0, 0, 0,
                    32'h0, 0, 0, 0, 32'h0, 4'h0);
        tv[9]  = mk(1, 0, 4'h2, 4'h0, 32'h0000_0041, 32'h0, 1, 2,
                    32'h0000_7700, 1, 0, 0, 32'h0000_0041, 4'h0);
        tv[10] = mk(1, 1, 4'hF, 4'h0, 32'h3000_0008, 32'h0, 0, 0,
                    32'h0, 0, 0, 0, 32'h0, 4'h0);

        cyc();
        cyc();
        chk_zero("reset");
        resetn = 1;

        // Directed table, issued back to back.
        for (int i = 0; i < 11; i++) begin
            vec_t v;
            v = tv[i];
            cyc();
            idle_in();
            en = v.en; ren = v.ren; wen = v.wen;
            maddr = v.addr; wdat = v.wdata; flush = v.fl;
            #1;
            chk($sformatf("v%0d_stall_t0", i), 32'(stall), 32'(v.acc));
            if (!v.acc) begin
                cyc();
                idle_in();
                #1;
                chk($sformatf("v%0d_no_req", i), 32'(bus.data_req), 0);
            end else begin
                for (int k = 0; k <= v.aok; k++) begin
                    cyc();
                    bus.data_addr_ok = (k == v.aok);
                    #1;
                    chk($sformatf("v%0d_req", i), 32'(bus.data_req), 1);
                    chk($sformatf("v%0d_stall_a", i), 32'(stall), 1);
                    chk($sformatf("v%0d_wr", i), 32'(bus.data_wr), 32'(v.wr));
                    chk($sformatf("v%0d_size", i), 32'(bus.data_size),
                        32'(v.size));
                    chk($sformatf("v%0d_addr", i), bus.data_addr, v.baddr);
                    chk($sformatf("v%0d_wstrb", i), 32'(bus.data_wstrb),
                        32'(v.strb));
                    if (v.wr)
                        chk($sformatf("v%0d_wdata", i), bus.data_wdata,
                            v.wdata);
                end
                for (int k = 0; k <= v.dok; k++) begin
                    cyc();
                    bus.data_addr_ok = 0;
                    bus.data_data_ok = (k == v.dok);
                    bus.data_rdata = (k == v.dok) ? v.rdata : $urandom;
                    #1;
                    chk($sformatf("v%0d_stall_d", i), 32'(stall), 1);
                    chk($sformatf("v%0d_valid_d", i), 32'(valid), 0);
                    chk($sformatf("v%0d_req_d", i), 32'(bus.data_req), 0);
                end
                cyc();
                bus.data_data_ok = 0;
                #1;
                chk($sformatf("v%0d_valid", i), 32'(valid), 1);
                chk($sformatf("v%0d_stall_done", i), 32'(stall), 0);
                chk($sformatf("v%0d_req_done", i), 32'(bus.data_req), 0);
                if (!v.wr)
                    chk($sformatf("v%0d_rdata", i), rdat, v.rdata);
            end
        end
        cyc();
        idle_in();

        // Flush in ADDR: request stays up, is drained, next access follows.
        cyc();
        present(4'hF, 4'h0, 32'h0000_0300, 32'h0);
        #1;
        chk("fa_stall0", 32'(stall), 1);
        cyc();
        flush = 1;
        #1;
        chk("fa_req", 32'(bus.data_req), 1);
        cyc();
        flush = 0;
        present(4'hF, 4'h0, 32'h0000_0400, 32'h0);
        #1;
        chk("fa_req_kept", 32'(bus.data_req), 1);
        chk("fa_addr_kept", bus.data_addr, 32'h0000_0300);
        chk("fa_stall1", 32'(stall), 1);
        cyc();
        bus.data_addr_ok = 1;
        #1;
        chk("fa_req_acc", 32'(bus.data_req), 1);
        cyc();
        bus.data_addr_ok = 0;
        #1;
        chk("fa_drain_req", 32'(bus.data_req), 0);
        chk("fa_drain_stall", 32'(stall), 1);
        chk("fa_drain_valid", 32'(valid), 0);
        cyc();
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("fa_drain2_stall", 32'(stall), 1);
        chk("fa_drain2_valid", 32'(valid), 0);
        cyc();
        bus.data_data_ok = 0;
        #1;
        chk("fa_idle_req", 32'(bus.data_req), 0);
        chk("fa_idle_stall", 32'(stall), 1);
        chk("fa_idle_valid", 32'(valid), 0);
        cyc();
        bus.data_addr_ok = 1;
        #1;
        chk("fa_new_req", 32'(bus.data_req), 1);
        chk("fa_new_addr", bus.data_addr, 32'h0000_0400);
        cyc();
        bus.data_addr_ok = 0;
        bus.data_data_ok = 1;
        bus.data_rdata = 32'h55AA_55AA;
        #1;
        cyc();
        bus.data_data_ok = 0;
        #1;
        chk("fa_new_valid", 32'(valid), 1);
        chk("fa_new_rdata", rdat, 32'h55AA_55AA);
        cyc();
        idle_in();

        // WB back-pressure in DONE, then a flush while still waiting.
        for (int p = 0; p < 2; p++) begin
            cyc();
            present(4'hF, 4'h0, 32'h0000_0500, 32'h0);
            cyc();
            bus.data_addr_ok = 1;
            cyc();
            bus.data_addr_ok = 0;
            bus.data_data_ok = 1;
            bus.data_rdata = 32'h1122_3344 + 32'(p);
            for (int k = 0; k < 4; k++) begin
                cyc();
                bus.data_data_ok = 0;
                bus.data_rdata = $urandom;
                wb = 0;
                bus.data_addr_ok = (k == 1);
                #1;
                chk("wbh_valid", 32'(valid), 1);
                chk("wbh_rdata", rdat, 32'h1122_3344 + 32'(p));
                chk("wbh_stall", 32'(stall), 0);
                chk("wbh_req", 32'(bus.data_req), 0);
            end
            cyc();
            bus.data_addr_ok = 0;
            if (p == 0) wb = 1;
            else flush = 1;
            #1;
            chk("wbh_last", 32'(valid), 1);
            cyc();
            idle_in();
            #1;
            chk("wbh_clear", 32'(valid), 0);
            chk("wbh_noreq", 32'(bus.data_req), 0);
        end

        // Reset while waiting for data; the late data_ok must be ignored.
        cyc();
        present(4'hF, 4'h0, 32'h0000_0600, 32'h0);
        cyc();
        bus.data_addr_ok = 1;
        cyc();
        bus.data_addr_ok = 0;
        resetn = 0;
        #1;
        chk("rst_in_data", 32'(stall), 1);
        cyc();
        resetn = 1;
        idle_in();
        bus.data_data_ok = 1;
        bus.data_rdata = 32'h7777_7777;
        #1;
        chk_zero("rst_mid");
        cyc();
        bus.data_data_ok = 0;
        #1;
        chk_zero("rst_after");

        // Random pipeline and memory, scored against the transaction model.
        cur   = rnd_ins();
        prv   = cur;
        prv_fl = 1;
        hold  = 0;
        outst = 0;
        last  = 0;
        quiet = 0;
        h_wr = 0; h_size = 0; h_addr = 0; h_strb = 0;
        for (int c = 0; c < 4000; c++) begin
            exp_t e;
            exp_t ec;
            cyc();
            en = cur.en; ren = cur.ren; wen = cur.wen;
            maddr = cur.addr; wdat = cur.wdata;
            flush = ($urandom % 25) == 0;
            wb = ($urandom % 4) != 0;
            bus.data_addr_ok = bus.data_req ? (($urandom % 3) == 0)
                                            : (($urandom % 8) == 0);
            bus.data_data_ok = outst ? (($urandom % 3) == 0)
                                     : (($urandom % 10) == 0);
            bus.data_rdata = $urandom;
            #1;
            if (hold) begin
                chk("r_req_held", 32'(bus.data_req), 1);
                chk("r_hold_addr", bus.data_addr, h_addr);
                chk("r_hold_size", 32'(bus.data_size), 32'(h_size));
                chk("r_hold_wr", 32'(bus.data_wr), 32'(h_wr));
                chk("r_hold_strb", 32'(bus.data_wstrb), 32'(h_strb));
            end else if (bus.data_req) begin
                e = ref_bus(prv, prv_fl);
                chk("r_one_outstanding", 32'(outst), 0);
                chk("r_req_cause", 32'(e.acc), 1);
                chk("r_wr", 32'(bus.data_wr), 32'(e.wr));
                chk("r_size", 32'(bus.data_size), 32'(e.size));
                chk("r_addr", bus.data_addr, e.addr);
                chk("r_strb", 32'(bus.data_wstrb), 32'(e.strb));
                if (e.wr)
                    chk("r_wdata", bus.data_wdata, prv.wdata);
            end
            if (outst && bus.data_data_ok) begin
                outst = 0;
                last  = bus.data_rdata;
            end
            if (bus.data_req && bus.data_addr_ok)
                outst = 1;
            ec = ref_bus(cur, flush);
            prv    = cur;
            prv_fl = flush;
            hold   = bus.data_req && !bus.data_addr_ok;
            h_wr   = bus.data_wr;
            h_size = bus.data_size;
            h_addr = bus.data_addr;
            h_strb = bus.data_wstrb;
            if (flush) begin
                cur = rnd_ins();
                quiet = 0;
            end else if (!stall && wb) begin
                chk("r_wb_valid", 32'(valid), 32'(ec.acc));
                if (ec.acc && !ec.wr)
                    chk("r_wb_rdata", rdat, last);
                cur = rnd_ins();
                quiet = 0;
            end else begin
                quiet++;
            end
            if (quiet > 150) begin
                total++;
                bad++;
                $display("FAIL watchdog: stalled %0d cycles, want <= 150",
                         quiet);
                break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
